// File: rtl/bar_pkg.sv
// Shared definitions for the bar-height producer and the colour mapper that reads its heights.
package bar_pkg;

    localparam int NUM_BARS = 10;
    localparam int BAR_H_W  = 10;

    typedef logic [BAR_H_W-1:0] bar_h_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        COMMIT = 1'b1
    } state_t;

endpackage

// File: rtl/bar_level_updater_if.sv
// Spectrum sample stream into the bar-height producer.
// A sample moves only on a cycle where sample_valid and sample_ready are both high. The master
// holds bin/mag steady while valid is high and ready is low; ready never depends on valid.
interface bar_level_updater_if #(
    parameter int MAG_W = 16
);
    logic             sample_valid;
    logic             sample_ready;
    logic [3:0]       sample_bin;
    logic [MAG_W-1:0] sample_mag;

    modport master (output sample_valid, sample_bin, sample_mag, input sample_ready);
    modport slave  (input sample_valid, sample_bin, sample_mag, output sample_ready);
endinterface

// File: rtl/bar_level_updater_sync.sv
// Brings the vertical-sync input into the Clk domain and flags its rising edge for one cycle.
module frame_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic rise_pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_pulse = r_sync & ~r_prev;
endmodule

// File: rtl/bar_level_updater.sv
// Tracks each bar's peak magnitude over a frame, then at the frame boundary writes one scaled,
// clipped, decay-limited height per cycle into the registered bar outputs.
module bar_level_updater
    import bar_pkg::*;
#(
    parameter int MAG_W = 16,
    parameter int SHIFT = 6,
    parameter int MAX_H = 400,
    parameter int DECAY = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_clk,
    bar_level_updater_if.slave          smp,
    output logic [BAR_H_W*NUM_BARS-1:0] bar_y_flat,
    output logic                        frame_done,
    output logic [7:0]                  drop_cnt,
    output logic                        overrun,
    output state_t                      dbg_state
);
    localparam int                 IDX_W    = $clog2(NUM_BARS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BARS - 1);
    localparam logic [3:0]         BIN_LIM  = 4'(NUM_BARS);
    localparam logic [MAG_W-1:0]   MAX_H_M  = MAG_W'(MAX_H);
    localparam bar_h_t             MAX_H_V  = BAR_H_W'(MAX_H);
    localparam bar_h_t             DECAY_V  = BAR_H_W'(DECAY);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [MAG_W-1:0]   r_acc [NUM_BARS];
    bar_h_t             r_bar [NUM_BARS];
    logic               r_frame_done;
    logic [7:0]         r_drop;
    logic               r_overrun;

    logic               w_rise;
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic [MAG_W-1:0]   w_shifted;
    bar_h_t             w_scaled;
    bar_h_t             w_old;
    bar_h_t             w_decayed;
    bar_h_t             w_new;

    frame_edge_sync u_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .async_in   (frame_clk),
        .rise_pulse (w_rise)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Samples are refused on the edge cycle so nothing lands in a frame that is already closing.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ACCUM: begin
                w_ready = ~w_rise;
                if (w_rise) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                w_last = (r_idx == LAST_IDX);
                if (w_last) begin
                    w_next_state = ACCUM;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    assign w_accept = smp.sample_valid & w_ready;

    // The decay floor is taken before subtracting so a small height cannot wrap to a tall bar.
    always_comb begin
        w_shifted = r_acc[r_idx] >> SHIFT;
        w_scaled  = (w_shifted > MAX_H_M) ? MAX_H_V : w_shifted[BAR_H_W-1:0];
        w_old     = r_bar[r_idx];
        w_decayed = (w_old > DECAY_V) ? (w_old - DECAY_V) : '0;
        w_new     = (w_scaled > w_decayed) ? w_scaled : w_decayed;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_drop       <= '0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < NUM_BARS; i++) begin
                r_acc[i] <= '0;
                r_bar[i] <= '0;
            end
        end else begin
            r_frame_done <= (r_state == COMMIT) && w_last;
            if (r_state == COMMIT) begin
                r_idx        <= w_last ? '0 : r_idx + 1'b1;
                r_bar[r_idx] <= w_new;
                r_acc[r_idx] <= '0;
                if (w_rise) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                r_idx <= '0;
            end
            if (w_accept) begin
                if (smp.sample_bin < BIN_LIM) begin
                    if (smp.sample_mag > r_acc[smp.sample_bin]) begin
                        r_acc[smp.sample_bin] <= smp.sample_mag;
                    end
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_flat
        assign bar_y_flat[BAR_H_W*g +: BAR_H_W] = r_bar[g];
    end

    assign smp.sample_ready = w_ready;
    assign frame_done       = r_frame_done;
    assign drop_cnt         = r_drop;
    assign overrun          = r_overrun;
    assign dbg_state        = r_state;
endmodule

// File: tb/tb_bar_level_updater.sv
// Directed bench for bar_level_updater: a per-frame height model checked every stable cycle.
module tb_bar_level_updater;
    import bar_pkg::*;

    localparam int MAG_W = 16;

    logic                        Clk = 1'b0;
    logic                        Reset;
    logic                        frame_clk;
    logic [BAR_H_W*NUM_BARS-1:0] bar_y_flat;
    logic                        frame_done;
    logic [7:0]                  drop_cnt;
    logic                        overrun;
    state_t                      dbg_state;

    bar_level_updater_if #(.MAG_W(MAG_W)) smp ();

    bar_level_updater #(
        .MAG_W (MAG_W),
        .SHIFT (6),
        .MAX_H (400),
        .DECAY (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .smp        (smp),
        .bar_y_flat (bar_y_flat),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int m_acc  [NUM_BARS];
    int m_bar  [NUM_BARS];
    int m_next [NUM_BARS];
    int m_drop;
    bit m_overrun;
    bit model_valid = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int bar_of(input int i);
        return int'(bar_y_flat[BAR_H_W*i +: BAR_H_W]);
    endfunction

    // Height after a frame: peak/64 capped at 400, but never below last height minus 8 (or 0).
    function automatic int commit_h(input int acc, input int old);
        int s;
        int d;
        s = acc / 64;
        if (s > 400) s = 400;
        d = old - 8;
        if (d < 0) d = 0;
        return (s > d) ? s : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_BARS; i++) begin
            m_acc[i] = 0;
            m_bar[i] = 0;
        end
        m_drop    = 0;
        m_overrun = 1'b0;
    endtask

    task automatic model_close_frame();
        for (int i = 0; i < NUM_BARS; i++) begin
            m_next[i] = commit_h(m_acc[i], m_bar[i]);
            m_acc[i]  = 0;
        end
    endtask

    task automatic model_accept(input int bin, input int mag);
        if (bin < NUM_BARS) begin
            if (mag > m_acc[bin]) m_acc[bin] = mag;
        end else if (m_drop < 255) begin
            m_drop++;
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (model_valid && !Reset) begin
                for (int i = 0; i < NUM_BARS; i++) begin
                    check($sformatf("cyc_bar%0d", i), bar_of(i), m_bar[i]);
                end
                check("cyc_drop_cnt", int'(drop_cnt), m_drop);
                check("cyc_overrun", int'(overrun), int'(m_overrun));
            end
        end
    end

    task automatic send_sample(input int bin, input int mag);
        int waited;
        waited = 0;
        @(negedge Clk);
        smp.sample_valid = 1'b1;
        smp.sample_bin   = 4'(bin);
        smp.sample_mag   = 16'(mag);
        while (!smp.sample_ready && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        check("sample_accept", int'(smp.sample_ready), 1);
        if (smp.sample_ready) model_accept(bin, mag);
        @(posedge Clk);
        #1;
        smp.sample_valid = 1'b0;
    endtask

    task automatic frame_edge(input bit second_edge, input string tag);
        int cyc;
        bit seen;
        @(negedge Clk);
        frame_clk   = 1'b1;
        model_valid = 1'b0;
        model_close_frame();
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge Clk);
            #2;
            cyc++;
            if (second_edge && cyc == 4) frame_clk = 1'b0;
            if (second_edge && cyc == 7) frame_clk = 1'b1;
            if (frame_done) seen = 1'b1;
        end
        check({tag, "_done_latency"}, seen ? cyc : -1, 13);
        for (int i = 0; i < NUM_BARS; i++) m_bar[i] = m_next[i];
        if (second_edge) m_overrun = 1'b1;
        model_valid = 1'b1;
        @(posedge Clk);
        #2;
        check({tag, "_done_pulse_width"}, int'(frame_done), 0);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic held_across_edge(input int bin, input int mag);
        int lows;
        int w;
        lows = 0;
        w    = 0;
        @(negedge Clk);
        frame_clk   = 1'b1;
        model_valid = 1'b0;
        model_close_frame();
        while (smp.sample_ready && w < 10) begin
            @(negedge Clk);
            w++;
        end
        check("held_ready_drop_delay", w, 2);
        smp.sample_valid = 1'b1;
        smp.sample_bin   = 4'(bin);
        smp.sample_mag   = 16'(mag);
        while (!smp.sample_ready && lows < 40) begin
            lows++;
            @(negedge Clk);
        end
        check("held_ready_low_cycles", lows, 11);
        check("held_frame_done", int'(frame_done), 1);
        for (int i = 0; i < NUM_BARS; i++) m_bar[i] = m_next[i];
        model_valid = 1'b1;
        if (smp.sample_ready) model_accept(bin, mag);
        @(posedge Clk);
        #1;
        smp.sample_valid = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic reset_mid_commit();
        @(negedge Clk);
        frame_clk   = 1'b1;
        model_valid = 1'b0;
        model_close_frame();
        repeat (7) @(posedge Clk);
        @(negedge Clk);
        check("mid_state_commit", int'(dbg_state == COMMIT), 1);
        for (int i = 0; i < NUM_BARS; i++) begin
            check($sformatf("mid_bar%0d", i), bar_of(i), (i < 4) ? m_next[i] : m_bar[i]);
        end
        Reset     = 1'b1;
        frame_clk = 1'b0;
        @(posedge Clk);
        #2;
        check("rst_mid_bars_zero", int'(bar_y_flat == '0), 1);
        check("rst_mid_state", int'(dbg_state == ACCUM), 1);
        check("rst_mid_frame_done", int'(frame_done), 0);
        check("rst_mid_drop_cnt", int'(drop_cnt), 0);
        check("rst_mid_overrun", int'(overrun), 0);
        model_reset();
        @(negedge Clk);
        Reset       = 1'b0;
        model_valid = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset            = 1'b1;
        frame_clk        = 1'b0;
        smp.sample_valid = 1'b0;
        smp.sample_bin   = '0;
        smp.sample_mag   = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #2;
        check("rst_bars_zero", int'(bar_y_flat == '0), 1);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_state", int'(dbg_state == ACCUM), 1);
        check("rst_ready", int'(smp.sample_ready), 1);
        model_valid = 1'b1;

        frame_edge(1'b0, "empty");
        check("empty_bars_zero", int'(bar_y_flat == '0), 1);

        send_sample(2, 100 << 6);
        send_sample(2, 50 << 6);
        frame_edge(1'b0, "bar2");
        check("bar2_first", bar_of(2), 100);
        check("bar2_model_pin", m_bar[2], 100);
        check("bar1_untouched", bar_of(1), 0);
        frame_edge(1'b0, "decay1");
        check("bar2_decay1", bar_of(2), 92);
        frame_edge(1'b0, "decay2");
        check("bar2_decay2", bar_of(2), 84);

        send_sample(0, 16'hFFFF);
        send_sample(3, 5 << 6);
        send_sample(4, 90 << 6);
        send_sample(4, 120 << 6);
        send_sample(4, 30 << 6);
        send_sample(5, 0);
        frame_edge(1'b0, "clip");
        check("bar0_clip", bar_of(0), 400);
        check("bar0_model_pin", m_bar[0], 400);
        check("bar3_small", bar_of(3), 5);
        check("bar4_peak", bar_of(4), 120);
        check("bar5_zero_mag", bar_of(5), 0);
        check("bar2_decay3", bar_of(2), 76);
        frame_edge(1'b0, "floor");
        check("bar3_floor", bar_of(3), 0);
        check("bar0_decay", bar_of(0), 392);

        for (int k = 0; k < 300; k++) send_sample(12, k);
        check("drop_saturated", int'(drop_cnt), 255);
        check("drop_bar0_kept", bar_of(0), 392);

        held_across_edge(7, 200 << 6);
        frame_edge(1'b0, "held");
        check("bar7_held", bar_of(7), 200);

        frame_edge(1'b1, "ovr");
        check("overrun_set", int'(overrun), 1);
        check("ovr_bar7", bar_of(7), 192);

        for (int i = 0; i < NUM_BARS; i++) send_sample(i, (20 * i + 30) << 6);
        reset_mid_commit();

        send_sample(9, 16'h4000);
        frame_edge(1'b0, "post_rst");
        check("post_rst_bar9", bar_of(9), 256);
        check("post_rst_bar0", bar_of(0), 0);

        model_valid = 1'b0;
        @(posedge Clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bar_level_updater.md
Name: bar_level_updater

Overview:
- Producer of the per-bar heights that the colour mapper reads. The colour mapper draws bar i where DrawY <= BAR_Y[i].
- Accepts spectrum magnitude samples (bin index + magnitude) over a valid/ready handshake.
- Keeps the running maximum of each bar over one video frame.
- At each frame boundary, commits scaled, clipped and peak-decayed heights into the registered bar-height outputs.

Parameters:
- NUM_BARS, 10, number of bars; bin indices 0..NUM_BARS-1 are valid.
- MAG_W, 16, magnitude sample width.
- SHIFT, 6, right shift applied to a magnitude to get a pixel height.
- MAX_H, 400, clip ceiling for a height in pixels.
- DECAY, 8, pixels a committed height may fall per frame.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  VGA vertical sync, asynchronous to Clk; a frame boundary is its rising edge.
- sample_valid  in  1  a sample is offered.
- sample_ready  out  1  the block can accept a sample this cycle.
- sample_bin  in  4  bar index of the sample.
- sample_mag  in  MAG_W  unsigned magnitude.
- bar_y_flat  out  10*NUM_BARS  packed heights; bar i occupies bits [10*i+9 : 10*i].
- frame_done  out  1  one-cycle pulse when a commit completes.
- drop_cnt  out  8  count of samples with an invalid bin; saturates at 255.
- overrun  out  1  sticky: a frame edge arrived while a commit was in progress.

Behaviour:
- Reset, synchronous and active-high, clears:
  - every accumulator, and every height in bar_y_flat, to 0;
  - frame_done, drop_cnt and overrun to 0;
  - the state to ACCUM and the synchroniser flops to 0.
- Reset is honoured in any state. A reset mid-COMMIT abandons the commit and all heights read 0 on the next cycle.
- frame_clk handling:
  - passes through a 2-flop synchroniser, then a previous-value register;
  - edge_det = synced value high AND previous value low;
  - edge_det is asserted 3 Clk cycles after the raw rising edge.
- States:
  - ACCUM: sample_ready = NOT edge_det. On edge_det, go to COMMIT with idx = 0.
  - COMMIT: sample_ready = 0. Handles one bar per cycle for idx = 0..NUM_BARS-1. After the last bar, pulse frame_done for one cycle and return to ACCUM.
- Sample acceptance:
  - A sample is accepted when sample_valid AND sample_ready are both high in the same cycle.
  - If sample_bin < NUM_BARS: acc[bin] <= max(acc[bin], sample_mag).
  - Otherwise the sample is consumed and dropped, and drop_cnt increments, saturating at 255.
  - sample_valid is allowed to stay high while ready is low; no sample is lost.
- Commit arithmetic for bar idx:
  - s = acc >> SHIFT, clipped to MAX_H, giving a 10-bit value.
  - d = old height - DECAY, floored at 0. The subtraction must not wrap.
  - new height = max(s, d).
  - acc[idx] is cleared to 0 in the same cycle.
- Commit timing:
  - bar_y_flat for bar idx changes on the clock edge ending COMMIT cycle idx.
  - Bars not yet processed keep their old value.
  - A full commit takes NUM_BARS cycles; frame_done asserts on the cycle after the last bar is written.
- Edge during COMMIT: the edge is ignored, overrun is set, and the current commit finishes normally.
- A sample with magnitude 0 is legal and has no effect on the accumulator.
- Worst-case magnitude is 0xFFFF: 0xFFFF >> 6 = 1023, which clips to 400.
- With no samples in a frame, every bar decays by DECAY per frame until it reaches 0.

Decomposition:
- Package bar_pkg holds:
  - NUM_BARS and BAR_H_W = 10;
  - the typedef bar_h_t as logic [9:0];
  - the state enum typedef {ACCUM, COMMIT}.
- The colour mapper shares bar_pkg for BAR_H_W.
- One sub-module: frame_edge_sync, containing the 2-flop synchroniser plus the rising-edge detector. It has inputs Clk, Reset and async_in, and output rise_pulse.

Test Plan:
- Reset then one frame edge with no samples -> all heights 0, frame_done pulses once, 13 cycles after the synced edge path starts (3 sync + 10 commit).
- Samples on bin 2 of 100<<6 and then 50<<6, then a frame edge -> bar 2 = 100, other bars 0. Next frame with no samples -> bar 2 = 92, then 84.
- sample_mag 0xFFFF on bin 0, then an edge -> bar 0 = 400. Height 5 with no samples for one frame -> 0, not wrapped.
- sample_bin 12 offered 300 times -> drop_cnt = 255 (saturated), all heights unchanged.
- sample_valid held high across an edge -> sample_ready is low on the edge_det cycle and for all 10 COMMIT cycles. The held sample is accepted on the first ACCUM cycle and lands in the following frame.
- Second frame_clk edge during COMMIT -> overrun = 1 and the commit completes. Reset asserted at COMMIT idx = 4 -> all outputs 0 next cycle and state = ACCUM.
